uart_rx: RTL and testbench

- Asynchronous serial receiver for the UART link: 8 data bits, LSB first, 1 start bit, 1 stop bit, no parity.
- Receive-side companion of the team's uart_tx (idle-high line, same bit-period constant).
- Sits between the external rx pin and the consumer logic. Delivers one byte plus a one-cycle done strobe per valid frame, and flags frames whose stop bit reads low.

---
 rtl/uart_pkg.sv | 25 ++
 rtl/uart_sync_edge.sv | 30 +++
 rtl/uart_rx.sv | 140 ++++++++++++++
 tb/tb_uart_rx.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART constants and receiver state encodings.
// Used by both uart_tx and uart_rx so the two sides agree on the bit period.
package uart_pkg;

    localparam int unsigned CNT_W     = 16;
    localparam int unsigned DATA_W    = 8;
    localparam int unsigned BIT_IDX_W = 3;

    // Silicon values at 50 MHz / 9600 baud
    localparam logic [CNT_W-1:0] T_1_BIT = 16'd5207;
    localparam logic [CNT_W-1:0] T_HALF  = 16'd2603;

    // Short bit period for simulation (10 clk per bit)
    localparam logic [CNT_W-1:0] SIM_T_1_BIT = 16'd9;
    localparam logic [CNT_W-1:0] SIM_T_HALF  = 16'd4;

    typedef enum logic [4:0] {
        S_IDLE  = 5'b00001,
        S_START = 5'b00010,
        S_DATA  = 5'b00100,
        S_STOP  = 5'b01000,
        S_DONE  = 5'b10000
    } uart_state_e;

endpackage

// File: rtl/uart_sync_edge.sv
// Two-flop synchronizer for the asynchronous rx line plus a falling-edge detector.
// All flops reset to 1 so an idle line produces no edge coming out of reset.
module uart_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic rx_i,
    output logic rx_o,
    output logic fall_c_o
);

    logic rx_s1_q;
    logic rx_s2_q;
    logic rx_d_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_s1_q <= 1'b1;
            rx_s2_q <= 1'b1;
            rx_d_q  <= 1'b1;
        end else begin
            rx_s1_q <= rx_i;
            rx_s2_q <= rx_s1_q;
            rx_d_q  <= rx_s2_q;
        end
    end

    assign rx_o     = rx_s2_q;
    assign fall_c_o = rx_d_q & ~rx_s2_q;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 8N1, LSB first, idle-high line.
// Emits one-cycle rx_done_o on a good frame and frame_err_o when the stop bit reads low.
module uart_rx
    import uart_pkg::*;
#(
    parameter logic [CNT_W-1:0] BIT_CNT  = T_1_BIT,
    parameter logic [CNT_W-1:0] HALF_CNT = T_HALF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_i,
    output logic [DATA_W-1:0] data_o,
    output logic              rx_done_o,
    output logic              frame_err_o,
    output logic              busy_o
);

    logic rx_s;
    logic fall_c;

    uart_state_e            state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [BIT_IDX_W-1:0]   idx_q, idx_d;
    logic [DATA_W-1:0]      shreg_q, shreg_d;
    logic                   stop_q, stop_d;
    logic [DATA_W-1:0]      data_q, data_d;
    logic                   done_q, done_d;
    logic                   err_q, err_d;
    logic                   busy_q, busy_d;

    uart_sync_edge u_sync (
        .clk      (clk),
        .rst      (rst),
        .rx_i     (rx_i),
        .rx_o     (rx_s),
        .fall_c_o (fall_c)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shreg_q <= '0;
            stop_q  <= 1'b0;
            data_q  <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shreg_q <= shreg_d;
            stop_q  <= stop_d;
            data_q  <= data_d;
            done_q  <= done_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
        end
    end

    // Next-state, counter and sampling logic; counter clears on every state change
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shreg_d = shreg_q;
        stop_d  = stop_q;
        data_d  = data_q;
        done_d  = 1'b0;
        err_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (fall_c) begin
                    state_d = S_START;
                end
            end
            S_START: begin
                if (cnt_q == HALF_CNT) begin
                    cnt_d = '0;
                    if (!rx_s) begin
                        state_d = S_DATA;
                        idx_d   = '0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DATA: begin
                if (cnt_q == BIT_CNT) begin
                    cnt_d          = '0;
                    shreg_d[idx_q] = rx_s;
                    if (idx_q == BIT_IDX_W'(DATA_W - 1)) begin
                        state_d = S_STOP;
                    end else begin
                        idx_d = idx_q + BIT_IDX_W'(1);
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_STOP: begin
                if (cnt_q == BIT_CNT) begin
                    cnt_d   = '0;
                    stop_d  = rx_s;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DONE: begin
                cnt_d   = '0;
                state_d = S_IDLE;
                if (stop_q) begin
                    data_d = shreg_q;
                    done_d = 1'b1;
                end else begin
                    err_d = 1'b1;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    assign data_o      = data_q;
    assign rx_done_o   = done_q;
    assign frame_err_o = err_q;
    assign busy_o      = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed self-checking bench for uart_rx at 10 clk per bit.
// A behavioural transmitter drives the line; a monitor logs every output pulse.
module tb_uart_rx;
    import uart_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx_i = 1'b1;
    logic [7:0] data_o;
    logic       rx_done_o;
    logic       frame_err_o;
    logic       busy_o;

    int cyc = 0;
    int n_cmp = 0;
    int n_bad = 0;
    int n_err = 0;
    int n_both = 0;
    int n_tx = 0;
    logic [7:0] q_data[$];
    int         q_cyc[$];

    localparam int BIT_CLK = 10;
    localparam int DONE_LAT = 99;

    uart_rx #(
        .BIT_CNT  (SIM_T_1_BIT),
        .HALF_CNT (SIM_T_HALF)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rx_i        (rx_i),
        .data_o      (data_o),
        .rx_done_o   (rx_done_o),
        .frame_err_o (frame_err_o),
        .busy_o      (busy_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst) begin
            if (rx_done_o) begin
                q_data.push_back(data_o);
                q_cyc.push_back(cyc);
            end
            if (frame_err_o) n_err++;
            if (rx_done_o && frame_err_o) n_both++;
        end
    end

    task automatic chk(input string tag, input int got, input int exp, input int tol = 0);
        n_cmp++;
        if (got < exp - tol || got > exp + tol) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) tol %0d",
                     tag, got, got, exp, exp, tol);
        end
    endtask

    task automatic clear_log();
        q_data.delete();
        q_cyc.delete();
        n_err = 0;
    endtask

    task automatic drive_bit(input logic v, input int n);
        rx_i = v;
        repeat (n) @(negedge clk);
    endtask

    // Full 8N1 frame; f returns the cycle at which the start bit was driven
    task automatic send_frame(input logic [7:0] b, input logic stop_v, output int f);
        f = cyc;
        drive_bit(1'b0, BIT_CLK);
        for (int i = 0; i < 8; i++) drive_bit(b[i], BIT_CLK);
        drive_bit(stop_v, BIT_CLK);
        rx_i = 1'b1;
        n_tx++;
    endtask

    initial begin
        int f0, f1;
        logic [7:0] lb [4];
        logic [7:0] b5a;
        lb[0] = 8'h01; lb[1] = 8'h80; lb[2] = 8'h55; lb[3] = 8'hAA;
        b5a = 8'h5A;

        repeat (3) @(negedge clk);
        chk("rst_data", int'(data_o), 0);
        chk("rst_done", int'(rx_done_o), 0);
        chk("rst_err", int'(frame_err_o), 0);
        chk("rst_busy", int'(busy_o), 0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // Single good frame
        clear_log();
        send_frame(8'hA5, 1'b1, f0);
        repeat (10) @(negedge clk);
        chk("a5_count", q_data.size(), 1);
        chk("a5_data", int'(data_o), 8'hA5);
        chk("a5_lat", (q_cyc.size() > 0) ? q_cyc[0] - f0 : -1, DONE_LAT, 1);
        chk("a5_err", n_err, 0);
        chk("a5_busy", int'(busy_o), 0);

        // Back-to-back frames, no idle gap
        clear_log();
        send_frame(8'h00, 1'b1, f0);
        send_frame(8'hFF, 1'b1, f1);
        repeat (10) @(negedge clk);
        chk("b2b_count", q_data.size(), 2);
        chk("b2b_d0", (q_data.size() > 0) ? int'(q_data[0]) : -1, 8'h00);
        chk("b2b_d1", (q_data.size() > 1) ? int'(q_data[1]) : -1, 8'hFF);
        chk("b2b_gap", (q_cyc.size() > 1) ? q_cyc[1] - q_cyc[0] : -1, 100, 1);
        chk("b2b_err", n_err, 0);

        // Short low glitch is rejected at the start-bit midpoint
        clear_log();
        drive_bit(1'b0, 3);
        drive_bit(1'b1, 2);
        chk("glitch_busy_hi", int'(busy_o), 1);
        repeat (6) @(negedge clk);
        chk("glitch_busy_lo", int'(busy_o), 0);
        repeat (20) @(negedge clk);
        chk("glitch_done", q_data.size(), 0);
        chk("glitch_err", n_err, 0);
        chk("glitch_data", int'(data_o), 8'hFF);

        // Bad stop bit, then recovery
        clear_log();
        send_frame(8'h3C, 1'b0, f0);
        repeat (10) @(negedge clk);
        chk("ferr_err", n_err, 1);
        chk("ferr_done", q_data.size(), 0);
        chk("ferr_data", int'(data_o), 8'hFF);
        send_frame(8'h81, 1'b1, f0);
        repeat (10) @(negedge clk);
        chk("rec_count", q_data.size(), 1);
        chk("rec_data", int'(data_o), 8'h81);
        chk("rec_err", n_err, 1);

        // Reset in the middle of data bit 4
        clear_log();
        drive_bit(1'b0, BIT_CLK);
        for (int i = 0; i < 4; i++) drive_bit(b5a[i], BIT_CLK);
        drive_bit(b5a[4], BIT_CLK / 2);
        rst = 1'b1;
        #1;
        chk("mrst_data", int'(data_o), 0);
        chk("mrst_busy", int'(busy_o), 0);
        chk("mrst_done", int'(rx_done_o), 0);
        chk("mrst_err", int'(frame_err_o), 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        rx_i = 1'b1;
        repeat (100) @(negedge clk);
        chk("mrst_nopulse", q_data.size() + n_err, 0);
        send_frame(8'h12, 1'b1, f0);
        repeat (10) @(negedge clk);
        chk("post_rst_count", q_data.size(), 1);
        chk("post_rst_data", int'(data_o), 8'h12);

        // Break: line held low gives a single frame error
        clear_log();
        drive_bit(1'b0, 250);
        chk("brk_err", n_err, 1);
        chk("brk_done", q_data.size(), 0);
        drive_bit(1'b1, 30);
        chk("brk_err_after", n_err, 1);
        chk("brk_data", int'(data_o), 8'h12);

        // Loopback-style stream from the behavioural transmitter
        clear_log();
        n_tx = 0;
        for (int i = 0; i < 4; i++) send_frame(lb[i], 1'b1, f0);
        repeat (10) @(negedge clk);
        chk("lb_count", q_data.size(), n_tx);
        for (int i = 0; i < 4; i++)
            chk($sformatf("lb_data%0d", i), (q_data.size() > i) ? int'(q_data[i]) : -1, int'(lb[i]));
        chk("lb_err", n_err, 0);

        chk("both_high", n_both, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
